factor_check_seq: RTL and testbench
===================================

// Module: factor_check_seq
// PURPOSE
//   Sequential, parametrised factorisation checker: accepts factors x, y (W bits)
//   and a target (2W bits), computes x*y by shift-and-add over W cycles, and
//   reports whether the product equals the target. Replaces fixed-width
//   combinational product-compare netlists in the factorisation benchmark flow
//   with a handshaked datapath.
// PARAMETERS
//   W      4   factor width in bits; target/product width is 2*W (W >= 2)
// PORTS
//   clk          in   1     single clock, all state on rising edge
//   rst          in   1     synchronous, active-high reset
//   in_valid     in   1     request valid
//   in_ready     out  1     block can accept a request (state IDLE)
//   x            in   W     multiplicand
//   y            in   W     multiplier
//   target       in   2W    value to compare against x*y
//   out_valid    out  1     result valid, held until out_ready
//   out_ready    in   1     consumer accepts result
//   out_match    out  1     1 iff product == target
//   out_product  out  2W    computed product (partial sum if aborted)
//   out_aborted  out  1     early-abort flag (see CONFIGURATION)
// BEHAVIOUR
//   - States: IDLE -> RUN -> DONE -> IDLE. in_ready = (state==IDLE).
//   - Reset: state IDLE; out_valid, out_match, out_aborted = 0; out_product = 0;
//     counter, accumulator cleared. Reset mid-RUN or mid-DONE drops the request.
//   - Accept on edge with in_valid && in_ready: mcand <= zero-extended x (2W),
//     msh <= y, tgt <= target, acc <= 0, cnt <= 0; state -> RUN.
//   - RUN, each edge: if msh[0] acc <= acc + mcand (2W add, never overflows);
//     mcand <= mcand << 1; msh <= msh >> 1; cnt <= cnt + 1.
//     On the edge where cnt == W-1: state -> DONE, out_product <= final acc,
//     out_match <= (final acc == tgt), out_valid <= 1.
//   - Latency: request accepted in cycle 0 -> out_valid high in cycle W+1,
//     fixed, independent of operand values (without the macro).
//   - DONE: outputs stable while out_valid && !out_ready. On out_valid &&
//     out_ready edge: out_valid <= 0, state -> IDLE. in_ready is low in DONE, so
//     a new request is accepted at the earliest in the cycle after handoff.
//   - out_product/out_match/out_aborted are meaningful only while out_valid.
//   - Operand 0 yields product 0; target 0 then matches. Max operands
//     (2^W-1)^2 fit in 2W bits.
// CONFIGURATION
//   FACTOR_CHECK_EARLY_ABORT_EN
//   - Defined: in RUN, if the next acc value exceeds tgt (partial sums are
//     monotone non-decreasing), go to DONE on that edge with out_match = 0,
//     out_aborted = 1, out_product = that partial acc. Latency becomes
//     variable, 2..W+1 cycles.
//   - Undefined: no comparison in RUN; out_aborted tied to 0; fixed latency.
// STRUCTURE
//   - factor_pkg: state enum (S_IDLE, S_RUN, S_DONE), localparams PW = 2*W
//     derivation helper and CNT_W = $clog2(W) (minimum 1).
//   - Sub-module factor_mac_step: combinational one-bit shift-add step
//     (acc, mcand, msh -> acc_nx, mcand_nx, msh_nx); top owns FSM, counter,
//     handshake, output registers.
// TESTING
//   1. W=4, x=13, y=11, target=143 -> out_valid in cycle 5, match=1, product=143.
//   2. W=4, x=15, y=15, target=224 -> match=0, product=225, aborted=0.
//   3. W=4, x=0, y=9, target=0 -> match=1, product=0; x=0,y=9,target=1 -> match=0.
//   4. Back-pressure: out_ready low 10 cycles after result -> outputs, out_valid
//      stable, in_ready low; in_valid held high is accepted only the cycle after handoff.
//   5. rst pulsed in RUN cycle 2 -> next cycle out_valid=0, in_ready=1, no result ever emitted.
//   6. EARLY_ABORT_EN, W=8, x=255, y=255, target=10 -> aborted=1, match=0,
//      out_valid in cycle 2, product=255; without macro -> cycle 9, product=65025.

Source files
------------

// File: rtl/factor_pkg.sv
// Shared types and width helpers for the sequential factorisation checker.
//   state_t   : FSM encoding (S_IDLE, S_RUN, S_DONE)
//   pw_of     : product/target width for a given factor width (2*W)
//   cnt_w_of  : step-counter width for a given factor width ($clog2(W), min 1)
package factor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int pw_of(input int w);
        return 2 * w;
    endfunction

    function automatic int cnt_w_of(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/factor_mac_step.sv
// One combinational shift-and-add step of the multiplier.
//   acc_i/mcand_i (PW bits), msh_i (W bits)  : current state
//   acc_o/mcand_o (PW bits), msh_o (W bits)  : state after this step
// The multiplicand is pre-zero-extended to PW bits and shifted left at
// most W-1 times, so acc + mcand never overflows PW bits.
module factor_mac_step #(
    parameter int W  = 4,
    parameter int PW = 8
) (
    input  logic [PW-1:0] acc_i,
    input  logic [PW-1:0] mcand_i,
    input  logic [W-1:0]  msh_i,
    output logic [PW-1:0] acc_o,
    output logic [PW-1:0] mcand_o,
    output logic [W-1:0]  msh_o
);

    assign acc_o   = msh_i[0] ? (acc_i + mcand_i) : acc_i;
    assign mcand_o = mcand_i << 1;
    assign msh_o   = msh_i >> 1;

endmodule

// File: rtl/factor_check_seq.sv
// Sequential factorisation checker: multiplies x*y by shift-and-add over
// W cycles and reports whether the product equals target.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : request handshake (ready only when IDLE)
//   x, y (W), target (2W)     : request operands
//   out_valid/out_ready       : result handshake, result held until taken
//   out_match, out_product    : comparison result and product (2W)
//   out_aborted               : early-abort flag
// Optional feature macro: FACTOR_CHECK_EARLY_ABORT_EN. When defined, the run
// stops as soon as a partial sum exceeds the target (partial sums only grow),
// giving variable latency; otherwise latency is fixed and out_aborted is 0.
module factor_check_seq
    import factor_pkg::*;
#(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      x,
    input  logic [W-1:0]      y,
    input  logic [2*W-1:0]    target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_match,
    output logic [2*W-1:0]    out_product,
    output logic              out_aborted
);

    localparam int PW    = pw_of(W);
    localparam int CNT_W = cnt_w_of(W);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [PW-1:0]     acc_q, mcand_q, tgt_q;
    logic [W-1:0]      msh_q;
    logic              out_valid_q, out_match_q, out_aborted_q;
    logic [PW-1:0]     out_product_q;

    logic [PW-1:0]     acc_d, mcand_d;
    logic [W-1:0]      msh_d;
    logic              last_step, abort_now;

    factor_mac_step #(.W(W), .PW(PW)) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .msh_i   (msh_q),
        .acc_o   (acc_d),
        .mcand_o (mcand_d),
        .msh_o   (msh_d)
    );

    assign last_step = (cnt_q == CNT_W'(W - 1));

`ifdef FACTOR_CHECK_EARLY_ABORT_EN
    assign abort_now = (acc_d > tgt_q);
`else
    assign abort_now = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            mcand_q       <= '0;
            msh_q         <= '0;
            tgt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_match_q   <= 1'b0;
            out_aborted_q <= 1'b0;
            out_product_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand_q <= PW'(x);
                        msh_q   <= y;
                        tgt_q   <= target;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_d;
                    msh_q   <= msh_d;
                    cnt_q   <= cnt_q + 1'b1;
                    // Abort wins over normal completion: once acc_d > tgt
                    // the product can only be larger, so there is no match.
                    if (abort_now || last_step) begin
                        state_q       <= S_DONE;
                        out_valid_q   <= 1'b1;
                        out_product_q <= acc_d;
                        out_match_q   <= !abort_now && (acc_d == tgt_q);
                        out_aborted_q <= abort_now;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign out_match   = out_match_q;
    assign out_product = out_product_q;
    assign out_aborted = out_aborted_q;

endmodule

// File: tb/tb_factor_check_seq.sv
module tb_factor_check_seq;

    logic       clk = 1'b0;
    logic       rst;

    // W = 4 instance
    logic       in_valid, in_ready, out_valid, out_ready, out_match, out_aborted;
    logic [3:0] x, y;
    logic [7:0] target, out_product;

    // W = 8 instance
    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_match8, out_aborted8;
    logic [7:0]  x8, y8;
    logic [15:0] target8, out_product8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    factor_check_seq #(.W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .target(target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_match(out_match), .out_product(out_product), .out_aborted(out_aborted)
    );

    factor_check_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .x(x8), .y(y8), .target(target8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_match(out_match8), .out_product(out_product8), .out_aborted(out_aborted8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; sample/drive 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request on dut4, then count the cycle in which out_valid rises
    // (acceptance cycle = cycle 0). Returns 99 on timeout.
    task automatic req4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] t,
                        output int lat);
        x = a; y = b; target = t; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = 99;
    endtask

    task automatic handoff4();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [7:0] p_hold;
        logic exp_ab;
        rst = 1'b1; in_valid = 0; out_ready = 0; x = 0; y = 0; target = 0;
        in_valid8 = 0; out_ready8 = 0; x8 = 0; y8 = 0; target8 = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_product", 32'(out_product), 0);
        check("rst_match", 32'(out_match), 0);
        check("rst_aborted", 32'(out_aborted), 0);

        // 1: 13*11 == 143
        req4(4'd13, 4'd11, 8'd143, lat);
        check("t1_latency", lat, 5);
        check("t1_match", 32'(out_match), 1);
        check("t1_product", 32'(out_product), 143);
        check("t1_aborted", 32'(out_aborted), 0);
        check("t1_in_ready_done", 32'(in_ready), 0);
        handoff4();
        check("t1_valid_drop", 32'(out_valid), 0);
        check("t1_in_ready_idle", 32'(in_ready), 1);

        // 2: 15*15 = 225 vs 224; partial 225 > 224 only on the final step
`ifdef FACTOR_CHECK_EARLY_ABORT_EN
        exp_ab = 1'b1;
`else
        exp_ab = 1'b0;
`endif
        req4(4'd15, 4'd15, 8'd224, lat);
        check("t2_latency", lat, 5);
        check("t2_match", 32'(out_match), 0);
        check("t2_product", 32'(out_product), 225);
        check("t2_aborted", 32'(out_aborted), 32'(exp_ab));
        handoff4();

        // 3: zero operand
        req4(4'd0, 4'd9, 8'd0, lat);
        check("t3a_match", 32'(out_match), 1);
        check("t3a_product", 32'(out_product), 0);
        handoff4();
        req4(4'd0, 4'd9, 8'd1, lat);
        check("t3b_match", 32'(out_match), 0);
        check("t3b_product", 32'(out_product), 0);
        handoff4();

        // 4: back-pressure, new request held high during DONE
        req4(4'd7, 4'd6, 8'd42, lat);
        check("t4_match", 32'(out_match), 1);
        p_hold = out_product;
        x = 4'd3; y = 4'd5; target = 8'd15; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", 32'(out_valid), 1);
            check("t4_hold_product", 32'(out_product), 32'(p_hold));
            check("t4_hold_match", 32'(out_match), 1);
            check("t4_hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();                      // handoff edge
        out_ready = 1'b0;
        check("t4_after_handoff_valid", 32'(out_valid), 0);
        check("t4_after_handoff_ready", 32'(in_ready), 1);
        tick();                      // held request accepted here
        in_valid = 1'b0;
        check("t4_accepted", 32'(in_ready), 0);
        lat = 1;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        check("t4_second_latency", lat, 5);
        check("t4_second_product", 32'(out_product), 15);
        check("t4_second_match", 32'(out_match), 1);
        handoff4();

        // 5: reset in RUN cycle 2 drops the request
        x = 4'd13; y = 4'd11; target = 8'd143; in_valid = 1'b1;
        tick();                      // accept
        in_valid = 1'b0;
        tick();                      // now in RUN cycle 2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", 32'(out_valid), 0);
        check("t5_in_ready", 32'(in_ready), 1);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) lat++;
        end
        check("t5_no_result", lat, 0);

        // 6: W=8, 255*255 vs target 10
        x8 = 8'd255; y8 = 8'd255; target8 = 16'd10; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 40) begin tick(); lat++; end
        check("t6_match", 32'(out_match8), 0);
`ifdef FACTOR_CHECK_EARLY_ABORT_EN
        check("t6_latency", lat, 2);
        check("t6_product", 32'(out_product8), 255);
        check("t6_aborted", 32'(out_aborted8), 1);
`else
        check("t6_latency", lat, 9);
        check("t6_product", 32'(out_product8), 65025);
        check("t6_aborted", 32'(out_aborted8), 0);
`endif
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check("t6_valid_drop", 32'(out_valid8), 0);
        check("t6_in_ready", 32'(in_ready8), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
